load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_lsu_pkg.sv | 17 +
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the load/store unit: request size codes and FSM states.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store merge.
module lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lanes;

  always_comb begin
    byte_sel  = rd_word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    byte_en   = 4'b1111;
    wdata_lanes = {wdata, wdata};
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{is_signed & byte_sel[7]}}, byte_sel};
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & half_sel[15]}}, half_sel};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Replicated store data lets each byte lane pick new or old data independently.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = byte_en[gi] ? wdata_lanes[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit FSM: single outstanding request, read-modify-write for sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned or reserved-size requests complete with resp_err.
module load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_reg;
  logic              signed_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       wdata_reg;
  logic [31:0]       store_word_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic              misaligned;
  logic              in_mem_state;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (req_size == SZ_RSVD) ||
                      (req_size == SZ_HALF && req_addr[0]) ||
                      (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  lsu_lane_align u_align (
    .size        (size_reg),
    .is_signed   (signed_reg),
    .addr_lo     (addr_reg[1:0]),
    .rd_word     (mem_rdata),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      signed_reg     <= 1'b0;
      size_reg       <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      store_word_reg <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            signed_reg <= req_signed;
            size_reg   <= req_size;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata[15:0];
            if (misaligned) begin
              rdata_reg <= '0;
              err_reg   <= 1'b1;
              state_reg <= RESP;
            end else if (!req_write) begin
              state_reg <= LOAD;
            end else if (req_size == SZ_BYTE || req_size == SZ_HALF) begin
              state_reg <= RMW_READ;
            end else begin
              // Full-word (and, untrapped, reserved-size) stores skip the read.
              store_word_reg <= req_wdata;
              state_reg      <= WRITE;
            end
          end
        end
        LOAD: begin
          rdata_reg <= load_data;
          err_reg   <= 1'b0;
          state_reg <= RESP;
        end
        RMW_READ: begin
          store_word_reg <= merged_word;
          state_reg      <= WRITE;
        end
        WRITE: begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
          state_reg <= RESP;
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_mem_state = (state_reg == LOAD) || (state_reg == RMW_READ) || (state_reg == WRITE);

  // Strobes are gated by reset so an interrupted RMW never commits.
  assign req_ready  = !reset && (state_reg == IDLE);
  assign mem_read   = !reset && ((state_reg == LOAD) || (state_reg == RMW_READ));
  assign mem_write  = !reset && (state_reg == WRITE);
  assign mem_addr   = in_mem_state ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata  = (state_reg == WRITE) ? store_word_reg : '0;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a word-array memory reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic        load_mem;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Bench-side memory: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] exp_rdata, word, v, mask;
    logic        exp_err, trap;
    int          exp_lat, exp_wr_at, exp_reads, wi, k, off, width;
    int          resp_at, wr_at, wr_cnt, rd_cnt;
    logic [31:0] got_rdata;
    logic        got_err;

    wi = int'(addr[7:2]);
    k  = int'(addr[1:0]);
    exp_err = 1'b0; exp_rdata = '0; exp_wr_at = -1; exp_reads = 0;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && k != 0);
`endif
    if (trap) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (!wr) begin
      exp_lat = 2; exp_reads = 1;
      word = ref_mem[wi];
      if (sz == 2'd0) begin
        v = (word >> (8 * k)) & 32'hFF;
        if (sg && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        v = (word >> (16 * (k / 2))) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v | 32'hFFFF0000;
      end else begin
        v = word;
      end
      exp_rdata = v;
    end else if (sz == 2'd0 || sz == 2'd1) begin
      exp_lat = 3; exp_wr_at = 2; exp_reads = 1;
      width = (sz == 2'd0) ? 8 : 16;
      off   = (sz == 2'd0) ? 8 * k : 16 * (k / 2);
      mask  = ((32'd1 << width) - 32'd1) << off;
      ref_mem[wi] = (ref_mem[wi] & ~mask) | ((wd << off) & mask);
    end else begin
      exp_lat = 2; exp_wr_at = 1;
      ref_mem[wi] = wd;
    end

    @(negedge clk);
    check_val("ready_idle", {31'd0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;

    resp_at = 0; wr_at = -1; wr_cnt = 0; rd_cnt = 0;
    got_rdata = '0; got_err = 1'b0;
    for (int c = 1; c <= 8 && resp_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) check_val("ready_busy", {31'd0, req_ready}, 32'd0);
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        wr_at = c;
        check_val("mem_wdata", mem_wdata, ref_mem[wi]);
      end
      if (mem_read || mem_write) check_val("mem_addr", mem_addr, {addr[31:2], 2'b00});
      if (resp_valid) begin
        resp_at   = c;
        got_rdata = resp_rdata;
        got_err   = resp_err;
      end
    end
    check_val("resp_latency", 32'(resp_at), 32'(exp_lat));
    check_val("resp_rdata", got_rdata, exp_rdata);
    check_val("resp_err", {31'd0, got_err}, {31'd0, exp_err});
    check_val("write_count", 32'(wr_cnt), (exp_wr_at > 0) ? 32'd1 : 32'd0);
    check_val("write_cycle", 32'(wr_at), 32'(exp_wr_at));
    check_val("read_seen", (rd_cnt > 0) ? 32'd1 : 32'd0, 32'(exp_reads));

    @(negedge clk);
    check_val("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check_val("rdata_hold", resp_rdata, exp_rdata);
    check_val("ready_after", {31'd0, req_ready}, 32'd1);
    check_val("addr_idle", mem_addr, 32'd0);
    check_val("mem_word", mem[wi], ref_mem[wi]);
    $display("txn %s size=%0d signed=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
             wr ? "st" : "ld", sz, sg, addr, wd, got_rdata, got_err, resp_at);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h88776655;
    reset = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_err", {31'd0, resp_err}, 32'd0);
    check_val("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_val("rst_mem_write", {31'd0, mem_write}, 32'd0);
    load_mem = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", {31'd0, req_ready}, 32'd1);

    run_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    run_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    run_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    run_txn(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);

    // Reset while the sub-word store sits in its read phase.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_val("rstmid_read", {31'd0, mem_read}, 32'd0);
    check_val("rstmid_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    check_val("rstmid_write2", {31'd0, mem_write}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rstmid_ready", {31'd0, req_ready}, 32'd1);
    check_val("rstmid_word", mem[4], ref_mem[4]);
    $display("txn st size=0 addr=00000010 interrupted by reset");

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
